// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MIPS multiply/divide controller.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIXUP
    } state_e;

    localparam int          MULDIV_ITERS = 32;
    localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;

    function automatic logic is_div_op(op_e op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(op_e op);
        return !op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/write/result bundle between the execute stage (master) and muldiv_ctrl (slave).
interface muldiv_if import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) ();

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration on the 64-bit accumulator: shift-add multiply or restoring divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        acc_next = acc;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh[WIDTH-1:0] - operand;
        if (is_div) begin
            // Remainder shifted left one bit; subtract the divisor only if it fits.
            if (rem_sh >= {1'b0, operand})
                acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MIPS mul/div controller owning HI/LO.
// Optional MULDIV_FAST_MULT_EN: single-cycle combinational MULT/MULTU.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CW = 6;

    state_e             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div0;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               sgn;
    logic               rs_neg;
    logic               rt_neg;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        sgn      = is_signed_op(bus.op);
        rs_neg   = sgn && bus.rs_data[WIDTH-1];
        rt_neg   = sgn && bus.rt_data[WIDTH-1];
        rs_mag   = rs_neg ? -bus.rs_data : bus.rs_data;
        rt_mag   = rt_neg ? -bus.rt_data : bus.rt_data;
        prod_fix = neg_lo ? -acc : acc;
        quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] ext_rs;
    logic [2*WIDTH-1:0] ext_rt;
    logic [2*WIDTH-1:0] fast_prod;

    // The low 2*WIDTH bits of an extended product are the same for signed and unsigned.
    always_comb begin
        ext_rs    = {{WIDTH{rs_neg}}, bus.rs_data};
        ext_rt    = {{WIDTH{rt_neg}}, bus.rt_data};
        fast_prod = ext_rs * ext_rt;
    end
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // NOTE: all state below is registered with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            div0    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div <= is_div_op(bus.op);
                        neg_lo <= rs_neg ^ rt_neg;
                        neg_hi <= rs_neg;
                        count  <= '0;
                        div0   <= 1'b0;
                        if (is_div_op(bus.op)) begin
                            busy_r  <= 1'b1;
                            operand <= rt_mag;
                            if (bus.rt_data == '0) begin
                                // Divide by zero skips iteration and commits the fixed pattern.
                                div0  <= 1'b1;
                                acc   <= {bus.rs_data, DIV0_LO};
                                state <= FIXUP;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, rs_mag};
                                state <= DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MULT_EN
                            {hi_r, lo_r} <= fast_prod;
                            done_r       <= 1'b1;
`else
                            busy_r  <= 1'b1;
                            operand <= rs_mag;
                            acc     <= {{WIDTH{1'b0}}, rt_mag};
                            state   <= MUL;
`endif
                        end
                    end else begin
                        if (bus.mthi) hi_r <= bus.wdata;
                        if (bus.mtlo) lo_r <= bus.wdata;
                    end
                end
                MUL, DIV: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CW'(MULDIV_ITERS - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    if (div0) begin
                        {hi_r, lo_r} <= acc;
                    end else if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        {hi_r, lo_r} <= prod_fix;
                    end
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: arithmetic reference model plus directed literal checks.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT  = 0;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 33;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one op, computed with plain 64-bit arithmetic.
    function automatic logic [63:0] model(op_e op, logic [31:0] a, logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          sq;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = ua * ub;
            OP_DIV: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else
                    r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycle model: an accepted op commits a fixed number of edges later.
    logic        model_valid = 1'b0;
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          m_left;
    logic [63:0] m_res;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
                model_valid = 1'b1;
            end else if (model_valid) begin
                m_done = 1'b0;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        {m_hi, m_lo} = m_res;
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else if (bus.start) begin
                    m_res = model(bus.op, bus.rs_data, bus.rt_data);
`ifdef MULDIV_FAST_MULT_EN
                    if (!bus.op[1]) begin
                        {m_hi, m_lo} = m_res;
                        m_done = 1'b1;
                    end else
`endif
                    begin
                        m_left = (bus.op[1] && bus.rt_data == 32'd0) ? 1 : 33;
                        m_busy = 1'b1;
                    end
                end else begin
                    if (bus.mthi) m_hi = bus.wdata;
                    if (bus.mtlo) m_lo = bus.wdata;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check("cyc_busy", {63'd0, bus.busy}, {63'd0, m_busy});
                check("cyc_done", {63'd0, bus.done}, {63'd0, m_done});
                check("cyc_hi",   {32'd0, bus.hi},   {32'd0, m_hi});
                check("cyc_lo",   {32'd0, bus.lo},   {32'd0, m_lo});
            end
        end
    end

    task automatic launch(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic hw, input logic lw, input logic [31:0] wd);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        bus.mthi = hw; bus.mtlo = lw; bus.wdata = wd;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (!bus.done && cyc < 60) begin
            if (bus.busy) bc++;
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input string name, input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat, input int exp_busy);
        int cyc;
        int bc;
        launch(op, a, b, 1'b0, 1'b0, 32'd0);
        wait_done(cyc, bc);
        check({name, "_hi"},   {32'd0, bus.hi}, {32'd0, exp_hi});
        check({name, "_lo"},   {32'd0, bus.lo}, {32'd0, exp_lo});
        check({name, "_lat"},  64'(cyc), 64'(exp_lat));
        check({name, "_busy"}, 64'(bc), 64'(exp_busy));
        @(negedge clk);
        check({name, "_done1"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int bc;
        int done_seen;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = OP_MULT; bus.rs_data = '0; bus.rt_data = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        run_op("mult",    OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, MUL_BUSY);
        run_op("multu",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, MUL_BUSY);
        run_op("div",     OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33);
        run_op("divu",    OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         33, 33);
        run_op("divu0",   OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1, 1);
        run_op("div0",    OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1, 1);
        run_op("div_ovf", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 33);
        run_op("div_mix", OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 33, 33);

        // Start and MTLO while busy must both be dropped.
`ifdef MULDIV_FAST_MULT_EN
        launch(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
`else
        launch(OP_MULT, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0);
`endif
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd9; bus.rt_data = 32'd3;
        bus.mtlo = 1'b1; bus.wdata = 32'h0000_DEAD;
        @(negedge clk);
        bus.start = 1'b0; bus.mtlo = 1'b0;
        wait_done(cyc, bc);
`ifdef MULDIV_FAST_MULT_EN
        check("busy_ign_hi", {32'd0, bus.hi}, 64'd2);
        check("busy_ign_lo", {32'd0, bus.lo}, 64'd14);
`else
        check("busy_ign_hi", {32'd0, bus.hi}, 64'd0);
        check("busy_ign_lo", {32'd0, bus.lo}, 64'd42);
`endif
        repeat (3) @(negedge clk);
        check("busy_ign_idle", {63'd0, bus.busy}, 64'd0);

        // MTHI then MTLO in IDLE.
        bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_hi", {32'd0, bus.hi}, 64'h1234);
`ifdef MULDIV_FAST_MULT_EN
        check("mthi_lo", {32'd0, bus.lo}, 64'd14);
`else
        check("mthi_lo", {32'd0, bus.lo}, 64'd42);
`endif
        bus.mtlo = 1'b1; bus.wdata = 32'h0000_BEEF;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mtlo_lo", {32'd0, bus.lo}, 64'hBEEF);
        check("mtlo_hi", {32'd0, bus.hi}, 64'h1234);

        // Reset at iteration 10 of a DIV aborts it without a done pulse.
        launch(OP_DIV, 32'd100, 32'd3, 1'b0, 1'b0, 32'd0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        check("rst_mid_nodone", 64'(done_seen), 64'd0);

        // Start wins over a same-cycle MTHI.
        launch(OP_MULTU, 32'd3, 32'd4, 1'b1, 1'b0, 32'h0000_5555);
        wait_done(cyc, bc);
        check("post_rst_hi", {32'd0, bus.hi}, 64'd0);
        check("post_rst_lo", {32'd0, bus.lo}, 64'd12);
        check("post_rst_lat", 64'(cyc), 64'(MUL_LAT));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle controller for the MIPS multiply/divide unit. It accepts MULT, MULTU, DIV and DIVU from the execute stage and sequences a 32-iteration shift-add multiply or restoring divide. It owns the architectural HI and LO registers, serves MTHI/MTLO writes, and raises `busy` so the CPU stalls MFHI/MFLO and further mul/div issues until the result is committed.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: issue strobe for a mul/div op.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_data` input 32: multiplicand or dividend.
- `rt_data` input 32: multiplier or divisor.
- `mthi` input 1: write `wdata` to HI.
- `mtlo` input 1: write `wdata` to LO.
- `wdata` input 32: MTHI/MTLO data.
- `busy` output 1: an operation is in flight.
- `done` output 1: one-cycle pulse when HI/LO have just been updated by an op.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE + `start`: latch operands, select unsigned or signed mode, clear the iteration counter, then go to MUL or DIV.
  - DIV/DIVU with `rt_data`==0 goes straight to FIXUP.
- MUL and DIV each run 32 iterations with a 6-bit counter 0..31. On count 31, go to FIXUP.
- FIXUP writes HI/LO, pulses `done` and returns to IDLE.
- Signed ops work on magnitudes (two's-complement negate if bit 31 is set), then FIXUP corrects signs:
  - Product is negated (64-bit) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Multiply result: HI = product[63:32], LO = product[31:0].
- Divide result: LO = quotient, HI = remainder.
- Divide by zero, both signed and unsigned: LO = 0xFFFFFFFF, HI = `rs_data`.
- 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0, with no trap.
- `start` while `busy`: ignored. The CPU must stall; there is no queueing.
- `mthi`/`mtlo` in IDLE: the register updates at the next edge.
- `mthi`/`mtlo` while `busy`: ignored.
- `start` and `mthi`/`mtlo` in the same cycle: `start` wins and the write is dropped.
- `hi`/`lo` change only on a FIXUP commit, an MTHI/MTLO write, or reset.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Reset mid-operation aborts the op. The reset values appear the cycle after the reset edge, and no `done` is issued.
- `start` sampled at edge N:
  - `busy`=1 from after edge N through edge N+33.
  - Edge N+33 commits HI/LO.
  - During the cycle after N+33, `done`=1 and `busy`=0, so a new `start` may be accepted at edge N+34.
- Divide by zero: `busy`=1 for one cycle, commit at edge N+1, `done` in the following cycle.
- `done` is registered and never high for two consecutive cycles from a single op.

## Configuration
- `MULDIV_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle combinational 64-bit product.
  - HI/LO are written at acceptance edge N, `done` is pulsed in the following cycle, and `busy` is never asserted.
  - The MUL state is unreachable.
- `MULDIV_FAST_MULT_EN` undefined: MULT/MULTU use the 34-edge iterative path. Divide timing is identical in both builds.

## Structure
- Package `muldiv_pkg` holds:
  - The `op` enum: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - The state enum.
  - `MULDIV_ITERS` = 32.
  - The divide-by-zero LO constant 0xFFFFFFFF.
- Sub-module `muldiv_step` holds one combinational iteration: the shift-add multiply step or the restoring subtract/shift divide step on the 64-bit accumulator.
- `muldiv_ctrl` holds the FSM, counter, sign fixup and HI/LO registers.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; `done` in the cycle after edge N+33; `busy` high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. With `MULDIV_FAST_MULT_EN`: same values, committed at edge N, `busy` never 1.
- DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 -> LO=3, HI=1.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, `busy` for 1 cycle. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- During a MULT: pulse `start` with DIVU and `mtlo` with 0xDEAD -> both ignored and the MULT result is committed. In IDLE, `mthi` with 0x1234 -> `hi`=0x1234 after the next edge and `lo` unchanged.
- Assert `reset` at iteration 10 of a DIV -> `busy`=0, `hi`=`lo`=0, no `done`. A following MULTU 3 × 4 -> LO=12, HI=0.
